pe_mac_acc: RTL and testbench

PE_MAC_ACC -- requirements
Module: pe_mac_acc

---
 rtl/pe_pkg.sv | 26 ++
 rtl/pe_mult_pipe.sv | 40 ++++
 rtl/pe_mac_acc.sv | 143 ++++++++++++++
 tb/tb_pe_mac_acc.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and width/bound helpers for the pe_mac_acc processing element.
package pe_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } pe_state_t;

  function automatic int len_w(input int acc_len_max);
    return $clog2(acc_len_max + 1);
  endfunction

  function automatic int acc_w(input int psum_w, input int acc_len_max);
    return psum_w + $clog2(acc_len_max);
  endfunction

  // Signed range of a psum_w-bit result, used when clamping the final sum.
  function automatic longint sat_hi(input int psum_w);
    return (longint'(1) <<< (psum_w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int psum_w);
    return -(longint'(1) <<< (psum_w - 1));
  endfunction

endpackage

// File: rtl/pe_mult_pipe.sv
// Signed multiplier with a MUL_LAT-deep product/valid pipeline (MUL_LAT >= 1).
module pe_mult_pipe #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int MUL_LAT  = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic signed [DATA_W-1:0]            data,
  input  logic                                in_val,
  input  logic signed [WEIGHT_W-1:0]          weight,
  output logic signed [DATA_W+WEIGHT_W-1:0]   prod,
  output logic                                prod_val,
  output logic                                busy
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  logic signed [PROD_W-1:0] prod_q [MUL_LAT];
  logic        [MUL_LAT-1:0] val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
    end else begin
      val_q[0] <= in_val;
      if (in_val) prod_q[0] <= PROD_W'(data) * PROD_W'(weight);
      for (int i = 1; i < MUL_LAT; i++) begin
        val_q[i]  <= val_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign prod     = prod_q[MUL_LAT-1];
  assign prod_val = val_q[MUL_LAT-1];
  assign busy     = |val_q;

endmodule

// File: rtl/pe_mac_acc.sv
// Weight-stationary MAC element: accumulates cfg_len products per window plus an upstream psum.
// Build option: define PE_SATURATE_EN to clamp the result instead of wrapping it.
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int WEIGHT_W    = 8,
  parameter  int PSUM_W      = 24,
  parameter  int MUL_LAT     = 3,
  parameter  int ACC_LEN_MAX = 16,
  localparam int LEN_W       = len_w(ACC_LEN_MAX)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LEN_W-1:0]           i_cfg_len,
  input  logic signed [DATA_W-1:0]   i_data,
  input  logic                       i_data_val,
  input  logic signed [WEIGHT_W-1:0] i_weight,
  input  logic                       i_weight_val,
  input  logic signed [PSUM_W-1:0]   i_psum,
  input  logic                       i_psum_val,
  output logic signed [PSUM_W-1:0]   o_psum,
  output logic                       o_psum_val,
  output logic                       o_busy
);

  localparam int ACC_W  = acc_w(PSUM_W, ACC_LEN_MAX);
  localparam int PROD_W = DATA_W + WEIGHT_W;
  // Headroom so acc + product + psum never wraps before the final reduction.
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 2;

  pe_state_t state, state_nxt;

  logic signed [WEIGHT_W-1:0] weight_reg;
  logic signed [PROD_W-1:0]   prod;
  logic                       prod_val;
  logic                       pipe_busy;
  logic [LEN_W-1:0]           count, len_reg, len_eff;
  logic signed [ACC_W-1:0]    acc, acc_base, prod_acc;
  logic signed [PSUM_W-1:0]   psum_reg, sum_out;
  logic signed [SUM_W-1:0]    sum_full;
  logic                       done;

  pe_mult_pipe #(
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .MUL_LAT (MUL_LAT)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (i_data),
    .in_val  (i_data_val),
    .weight  (weight_reg),
    .prod    (prod),
    .prod_val(prod_val),
    .busy    (pipe_busy)
  );

  always_comb begin
    len_eff = i_cfg_len;
    if (i_cfg_len == '0) len_eff = LEN_W'(1);
    else if (i_cfg_len > LEN_W'(ACC_LEN_MAX)) len_eff = LEN_W'(ACC_LEN_MAX);
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (prod_val) begin
          if (len_eff == LEN_W'(1)) done = 1'b1;
          else state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        if (prod_val && (count + LEN_W'(1) == len_reg)) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign prod_acc = ACC_W'(prod);
  assign acc_base = (state == S_ACC) ? acc : '0;
  assign sum_full = SUM_W'(acc_base) + SUM_W'(prod) + SUM_W'(psum_reg);

`ifdef PE_SATURATE_EN
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_hi(PSUM_W));
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_lo(PSUM_W));

  always_comb begin
    sum_out = PSUM_W'(sum_full);
    if (sum_full > SAT_HI) sum_out = PSUM_W'(SAT_HI);
    else if (sum_full < SAT_LO) sum_out = PSUM_W'(SAT_LO);
  end
`else
  always_comb begin
    sum_out = PSUM_W'(sum_full);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      weight_reg <= '0;
      count      <= '0;
      len_reg    <= '0;
      acc        <= '0;
      psum_reg   <= '0;
      o_psum     <= '0;
      o_psum_val <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_psum_val <= done;
      if (i_weight_val) weight_reg <= i_weight;
      if (prod_val) begin
        if (state == S_IDLE) begin
          acc     <= prod_acc;
          count   <= LEN_W'(1);
          len_reg <= len_eff;
        end else begin
          acc   <= acc + prod_acc;
          count <= count + LEN_W'(1);
        end
      end
      // Completion clears the window and the captured psum; a psum arriving
      // in the completing cycle belongs to neither window and is dropped.
      if (done) begin
        o_psum   <= sum_out;
        psum_reg <= '0;
        count    <= '0;
        acc      <= '0;
      end else if (i_psum_val) begin
        psum_reg <= i_psum;
      end
    end
  end

  assign o_busy = (state == S_ACC) || pipe_busy;

endmodule

// File: tb/tb_pe_mac_acc.sv
// Self-checking bench for pe_mac_acc: directed vector table, corner sequences, random vs. model.
module tb_pe_mac_acc;

  localparam int LEN_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic [LEN_W-1:0]  cfg_len = '0;
  logic signed [7:0] data = '0, weight = '0;
  logic              data_val = 1'b0, weight_val = 1'b0, psum_val = 1'b0;
  logic signed [23:0] psum = '0, psum_o;
  logic              psum_o_val, busy;

  logic [LEN_W-1:0]  s_cfg_len = '0;
  logic signed [7:0] s_data = '0, s_weight = '0;
  logic              s_data_val = 1'b0, s_weight_val = 1'b0, s_psum_val = 1'b0;
  logic signed [7:0] s_psum = '0, s_psum_o;
  logic              s_psum_o_val, s_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_mac_acc dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_len(cfg_len),
    .i_data(data), .i_data_val(data_val),
    .i_weight(weight), .i_weight_val(weight_val),
    .i_psum(psum), .i_psum_val(psum_val),
    .o_psum(psum_o), .o_psum_val(psum_o_val), .o_busy(busy)
  );

  pe_mac_acc #(.PSUM_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_cfg_len(s_cfg_len),
    .i_data(s_data), .i_data_val(s_data_val),
    .i_weight(s_weight), .i_weight_val(s_weight_val),
    .i_psum(s_psum), .i_psum_val(s_psum_val),
    .o_psum(s_psum_o), .o_psum_val(s_psum_o_val), .o_busy(s_busy)
  );

  typedef struct {
    int weight;
    int len;
    int n;
    int d [16];
    int psum_idx;
    int psum;
    int expect_val;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    data_val = 1'b0; weight_val = 1'b0; psum_val = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for the main DUT strobe, then checks timing and value.
  task automatic wait_out(input string name, input int t_exp, input int exp_val);
    int waited = 0;
    while (!psum_o_val && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_valid"}, int'(psum_o_val), 1);
    check({name, "_cycle"}, cyc, t_exp);
    check({name, "_value"}, int'($signed(psum_o)), exp_val);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int t_last = 0;
    @(negedge clk);
    weight = 8'(v.weight); weight_val = 1'b1; cfg_len = LEN_W'(v.len);
    data_val = 1'b0; psum_val = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      weight_val = 1'b0;
      data = 8'(v.d[i]); data_val = 1'b1;
      psum_val = (i == v.psum_idx); psum = 24'(v.psum);
      t_last = cyc;
    end
    @(negedge clk);
    idle_inputs();
    check({name, "_busy"}, int'(busy), 1);
    wait_out(name, t_last + 4, v.expect_val);
    @(negedge clk);
    check({name, "_strobe_off"}, int'(psum_o_val), 0);
    check({name, "_hold"}, int'($signed(psum_o)), v.expect_val);
  endtask

  function automatic int reduce24(input longint x);
`ifdef PE_SATURATE_EN
    if (x > 64'sd8388607) return 8388607;
    if (x < -64'sd8388608) return -8388608;
    return int'(x);
`else
    logic signed [23:0] t;
    t = x[23:0];
    return int'(t);
`endif
  endfunction

  // Reference model state for the random phase.
  int     pend_cyc [$];
  longint pend_prod [$];
  int     exp_val [$];
  int     exp_cyc [$];

  initial begin
    int t1, t2, seen, n_rnd;
    int m_weight, m_len, m_cnt;
    bit m_open, m_done;
    longint m_sum, m_psum, p;
    vec_t v;

    for (int k = 0; k < 7; k++) begin
      vecs[k].psum_idx = -1;
      vecs[k].psum = 0;
      for (int i = 0; i < 16; i++) vecs[k].d[i] = i + 1;
    end
    vecs[0].weight = 3;  vecs[0].len = 4;  vecs[0].n = 4;  vecs[0].expect_val = 30;
    vecs[1].weight = 3;  vecs[1].len = 4;  vecs[1].n = 4;  vecs[1].expect_val = 130;
    vecs[1].psum_idx = 1; vecs[1].psum = 100;
    vecs[2].weight = 3;  vecs[2].len = 4;  vecs[2].n = 4;  vecs[2].expect_val = 30;
    vecs[3].weight = -2; vecs[3].len = 0;  vecs[3].n = 1;  vecs[3].expect_val = -10;
    vecs[3].d[0] = 5;
    vecs[4].weight = 1;  vecs[4].len = 31; vecs[4].n = 16; vecs[4].expect_val = 136;
    vecs[5].weight = -5; vecs[5].len = 3;  vecs[5].n = 3;  vecs[5].expect_val = -3;
    vecs[5].d[0] = 7; vecs[5].d[1] = -8; vecs[5].d[2] = 1;
    vecs[5].psum_idx = 2; vecs[5].psum = -3;
    vecs[6].weight = 1;  vecs[6].len = 4;  vecs[6].n = 4;  vecs[6].expect_val = 4;
    for (int i = 0; i < 4; i++) vecs[6].d[i] = 1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_psum", int'($signed(psum_o)), 0);
    check("rst_val", int'(psum_o_val), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Weight load and product issue in the same cycle: the product sees the old weight.
    @(negedge clk);
    weight = 8'sd1; weight_val = 1'b1; cfg_len = LEN_W'(1);
    @(negedge clk);
    weight = 8'sd7; weight_val = 1'b1; data = 8'sd2; data_val = 1'b1; t1 = cyc;
    @(negedge clk);
    weight_val = 1'b0; data = 8'sd1; t2 = cyc;
    @(negedge clk);
    idle_inputs();
    wait_out("same_cyc_w_old", t1 + 4, 2);
    @(negedge clk);
    wait_out("same_cyc_w_new", t2 + 4, 7);

    // Reset in the middle of a window discards in-flight products.
    @(negedge clk);
    weight = 8'sd1; weight_val = 1'b1; cfg_len = LEN_W'(4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      weight_val = 1'b0; data = 8'sd1; data_val = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_psum", int'($signed(psum_o)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (psum_o_val) seen++;
    end
    check("midrst_no_out", seen, 0);
    check("midrst_idle_busy", int'(busy), 0);
    run_vec("post_rst", vecs[6]);

    // Narrow result path: 127*127*2 overflows an 8-bit psum.
    @(negedge clk);
    s_weight = 8'sd127; s_weight_val = 1'b1; s_cfg_len = LEN_W'(2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_weight_val = 1'b0; s_data = 8'sd127; s_data_val = 1'b1;
    end
    @(negedge clk);
    s_data_val = 1'b0;
    seen = 0;
    while (!s_psum_o_val && seen < 20) begin @(negedge clk); seen++; end
    check("sat8_pos_valid", int'(s_psum_o_val), 1);
`ifdef PE_SATURATE_EN
    check("sat8_pos_value", int'($signed(s_psum_o)), 127);
`else
    check("sat8_pos_value", int'($signed(s_psum_o)), 2);
`endif
    @(negedge clk);
    s_weight = 8'sd127; s_weight_val = 1'b1; s_cfg_len = LEN_W'(2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_weight_val = 1'b0; s_data = -8'sd128; s_data_val = 1'b1;
    end
    @(negedge clk);
    s_data_val = 1'b0;
    seen = 0;
    while (!s_psum_o_val && seen < 20) begin @(negedge clk); seen++; end
    check("sat8_neg_valid", int'(s_psum_o_val), 1);
`ifdef PE_SATURATE_EN
    check("sat8_neg_value", int'($signed(s_psum_o)), -128);
`else
    check("sat8_neg_value", int'($signed(s_psum_o)), 0);
`endif

    // Random traffic against a window-level reference model.
    do_reset();
    m_weight = 0; m_open = 1'b0; m_len = 0; m_cnt = 0; m_sum = 0; m_psum = 0;
    n_rnd = 0;
    for (int c = 0; c < 640; c++) begin
      @(negedge clk);
      if (psum_o_val) begin
        if (exp_val.size() == 0) begin
          check("rnd_spurious_out", 1, 0);
        end else begin
          check("rnd_value", int'($signed(psum_o)), exp_val.pop_front());
          check("rnd_cycle", cyc, exp_cyc.pop_front());
          n_rnd++;
        end
      end else if (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
        check("rnd_missing_out", 0, exp_val.pop_front());
        void'(exp_cyc.pop_front());
      end
      check("rnd_busy", int'(busy), int'(m_open || pend_cyc.size() > 0));

      if (c < 600) begin
        data_val   = ($urandom_range(0, 3) != 0);
        data       = 8'($urandom);
        weight_val = ($urandom_range(0, 7) == 0);
        weight     = 8'($urandom);
        psum_val   = ($urandom_range(0, 9) == 0);
        psum       = 24'($urandom);
        if ($urandom_range(0, 15) == 0) cfg_len = LEN_W'($urandom_range(0, 20));
      end else begin
        idle_inputs();
      end

      if (data_val) begin
        pend_cyc.push_back(cyc);
        pend_prod.push_back(longint'(int'(data) * m_weight));
      end
      if (weight_val) m_weight = int'(weight);
      m_done = 1'b0;
      if (pend_cyc.size() > 0 && pend_cyc[0] + 3 == cyc) begin
        void'(pend_cyc.pop_front());
        p = pend_prod.pop_front();
        if (!m_open) begin
          m_len  = (cfg_len == 0) ? 1 : ((int'(cfg_len) > 16) ? 16 : int'(cfg_len));
          m_open = 1'b1;
          m_cnt  = 1;
          m_sum  = p;
        end else begin
          m_cnt++;
          m_sum += p;
        end
        if (m_cnt == m_len) begin
          exp_val.push_back(reduce24(m_sum + m_psum));
          exp_cyc.push_back(cyc + 1);
          m_open = 1'b0;
          m_done = 1'b1;
        end
      end
      if (m_done) m_psum = 0;
      else if (psum_val) m_psum = longint'(psum);
    end
    check("rnd_all_drained", exp_val.size(), 0);
    check("rnd_saw_outputs", int'(n_rnd > 20), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
